// File: rtl/i2s_capture_writer.sv
// I2S receiver feeding a small sample FIFO that is drained into an SDRAM write port.
// Captured words land L,R interleaved across an inclusive word-address region.
module i2s_capture_writer #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk50,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        loop,
  input  logic [24:0] addr_start,
  input  logic [24:0] addr_end,
  input  logic        I2S_SCLK,
  input  logic        I2S_LRCLK,
  input  logic        I2S_DOUT,
  output logic        ram_we,
  output logic [24:0] ram_address,
  output logic [15:0] ram_data,
  input  logic        ram_op_begun,
  output logic        done,
  output logic        overflow,
  output logic [3:0]  hex_out_5,
  output logic [3:0]  hex_out_4,
  output logic [3:0]  hex_out_3,
  output logic [3:0]  hex_out_2,
  output logic [3:0]  hex_out_1,
  output logic [3:0]  hex_out_0
);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] WRITE   = 2'd1;
  localparam logic [1:0] RELEASE = 2'd2;
  localparam logic [1:0] HALT    = 2'd3;

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(DATA_W + 1);

  logic [2:0]        sync1, sync2;
  logic              sclk_d, sclk_rise, lr_s, dout_s;
  logic              en_d, run, live, en_rise;
  logic              lr_prev, active, armed, word_vld;
  logic [CW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [15:0]       word16;
  logic [15:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [AW:0]       count;
  logic              full, push_req, push_ok, pop;
  logic [1:0]        state;
  logic [24:0]       reg_start, reg_end;
  logic              restart_pend, end_hit;

  // All three pins share one synchronizer chain so LRCLK/DOUT stay aligned to SCLK.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= '0;
      sync2  <= '0;
      sclk_d <= 1'b0;
    end else begin
      sync1  <= {I2S_SCLK, I2S_LRCLK, I2S_DOUT};
      sync2  <= sync1;
      sclk_d <= sync2[2];
    end
  end

  assign sclk_rise = sync2[2] & ~sclk_d;
  assign lr_s      = sync2[1];
  assign dout_s    = sync2[0];

  // en_d resets high so an enable held across reset is not mistaken for a fresh start.
  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      en_d <= 1'b1;
      run  <= 1'b0;
    end else begin
      en_d <= enable;
      if (!enable)      run <= 1'b0;
      else if (en_rise) run <= 1'b1;
    end
  end

  assign en_rise = enable & ~en_d;
  assign live    = enable & run;

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      lr_prev  <= 1'b0;
      active   <= 1'b0;
      armed    <= 1'b0;
      word_vld <= 1'b0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else begin
      word_vld <= 1'b0;
      if (sclk_rise) lr_prev <= lr_s;
      if (!live) begin
        active  <= 1'b0;
        armed   <= 1'b0;
        bit_cnt <= '0;
      end else if (sclk_rise) begin
        if (lr_s != lr_prev) begin
          // delay slot: the bit on this edge still belongs to the previous word
          active  <= 1'b1;
          bit_cnt <= '0;
          if (!lr_s) armed <= 1'b1;
        end else if (active) begin
          shreg   <= {shreg[DATA_W-2:0], dout_s};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_cnt == CW'(DATA_W - 1)) begin
            active   <= 1'b0;
            word_vld <= armed;
          end
        end
      end
    end
  end

  generate
    if (DATA_W >= 16) begin : g_trunc
      assign word16 = shreg[DATA_W-1 -: 16];
    end else begin : g_pad
      assign word16 = {shreg, {(16 - DATA_W){1'b0}}};
    end
  endgenerate

  assign full     = (count == (AW + 1)'(FIFO_DEPTH));
  assign push_req = word_vld & live;
  assign push_ok  = push_req & (~full | pop);
  assign pop      = (state == IDLE) && live && !done && (count != '0);

  always_ff @(posedge clk50) begin
    if (push_ok) mem[wr_ptr] <= word16;
  end

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (en_rise)                      overflow <= 1'b0;
      else if (push_req && full && !pop) overflow <= 1'b1;
      if (!live) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= (wr_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
        if (pop)     rd_ptr <= (rd_ptr == AW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
        case ({push_ok, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  // An inverted region counts as already at its end after the first write.
  assign end_hit = (ram_address == reg_end) || (reg_end < reg_start);

  always_ff @(posedge clk50 or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      ram_we       <= 1'b0;
      ram_address  <= '0;
      ram_data     <= '0;
      done         <= 1'b0;
      reg_start    <= '0;
      reg_end      <= '0;
      restart_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (en_rise) begin
            ram_address <= addr_start;
            reg_start   <= addr_start;
            reg_end     <= addr_end;
            done        <= 1'b0;
          end else if (pop) begin
            ram_data <= mem[rd_ptr];
            ram_we   <= 1'b1;
            state    <= WRITE;
          end
        end
        WRITE: begin
          // a restart during an in-flight write is applied once the write retires
          if (en_rise) restart_pend <= 1'b1;
          if (ram_op_begun) begin
            ram_we <= 1'b0;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          state        <= IDLE;
          restart_pend <= 1'b0;
          if (en_rise || restart_pend) begin
            ram_address <= addr_start;
            reg_start   <= addr_start;
            reg_end     <= addr_end;
            done        <= 1'b0;
          end else if (!end_hit) begin
            ram_address <= ram_address + 25'd1;
          end else if (loop) begin
            ram_address <= addr_start;
            reg_start   <= addr_start;
            reg_end     <= addr_end;
          end else begin
            done  <= 1'b1;
            state <= HALT;
          end
        end
        default: begin
          if (en_rise) begin
            ram_address <= addr_start;
            reg_start   <= addr_start;
            reg_end     <= addr_end;
            done        <= 1'b0;
            state       <= IDLE;
          end
        end
      endcase
    end
  end

  assign hex_out_5 = ram_address[23:20];
  assign hex_out_4 = ram_address[19:16];
  assign hex_out_3 = ram_address[15:12];
  assign hex_out_2 = ram_address[11:8];
  assign hex_out_1 = ram_address[7:4];
  assign hex_out_0 = ram_address[3:0];

endmodule

// File: tb/tb_i2s_capture_writer.sv
// Bench for i2s_capture_writer: drives an I2S master stream and an arbiter ack,
// checks every SDRAM write against a queue of expected {address, data}.
module tb_i2s_capture_writer;
  logic        clk50 = 1'b0;
  logic        reset_n, enable, loop;
  logic [24:0] addr_start, addr_end;
  logic        I2S_SCLK, I2S_LRCLK, I2S_DOUT;
  logic        ram_we, ram_op_begun, done, overflow;
  logic [24:0] ram_address;
  logic [15:0] ram_data;
  logic [3:0]  hex_out_5, hex_out_4, hex_out_3, hex_out_2, hex_out_1, hex_out_0;

  int          checks = 0;
  int          errors = 0;
  int          writes = 0;
  bit          ack_en = 1'b0;
  logic [40:0] sb[$];
  logic [40:0] cur_exp;
  logic        we_d = 1'b0;

  i2s_capture_writer #(.DATA_W(16), .FIFO_DEPTH(4)) dut (
    .clk50(clk50), .reset_n(reset_n), .enable(enable), .loop(loop),
    .addr_start(addr_start), .addr_end(addr_end),
    .I2S_SCLK(I2S_SCLK), .I2S_LRCLK(I2S_LRCLK), .I2S_DOUT(I2S_DOUT),
    .ram_we(ram_we), .ram_address(ram_address), .ram_data(ram_data),
    .ram_op_begun(ram_op_begun), .done(done), .overflow(overflow),
    .hex_out_5(hex_out_5), .hex_out_4(hex_out_4), .hex_out_3(hex_out_3),
    .hex_out_2(hex_out_2), .hex_out_1(hex_out_1), .hex_out_0(hex_out_0)
  );

  always #10 clk50 = ~clk50;

  // arbiter model: acknowledge two cycles after a request is seen
  initial begin
    ram_op_begun = 1'b0;
    forever begin
      @(posedge clk50); #1;
      if (ack_en && ram_we === 1'b1) begin
        repeat (2) @(posedge clk50);
        #1;
        if (ack_en && ram_we === 1'b1) begin
          ram_op_begun = 1'b1;
          @(posedge clk50); #1;
          ram_op_begun = 1'b0;
        end
      end
    end
  end

  // scoreboard: pop on each new write request, re-check the held values at ack
  initial begin
    forever begin
      @(negedge clk50);
      if (ram_we === 1'b1 && we_d !== 1'b1) begin
        writes++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          cur_exp = 'x;
          $display("FAIL unexpected_write: got addr=%h data=%h, expected no write", ram_address, ram_data);
        end else begin
          cur_exp = sb.pop_front();
          if ({ram_address, ram_data} !== cur_exp) begin
            errors++;
            $display("FAIL write_value: got addr=%h data=%h, expected addr=%h data=%h",
                     ram_address, ram_data, cur_exp[40:16], cur_exp[15:0]);
          end
          checks++;
          if ({hex_out_5, hex_out_4, hex_out_3, hex_out_2, hex_out_1, hex_out_0} !== cur_exp[39:16]) begin
            errors++;
            $display("FAIL hex_digits: got %h, expected %h",
                     {hex_out_5, hex_out_4, hex_out_3, hex_out_2, hex_out_1, hex_out_0}, cur_exp[39:16]);
          end
        end
      end
      if (ram_we === 1'b1 && ram_op_begun === 1'b1 && !$isunknown(cur_exp)) begin
        checks++;
        if ({ram_address, ram_data} !== cur_exp) begin
          errors++;
          $display("FAIL write_hold: got addr=%h data=%h at ack, expected addr=%h data=%h",
                   ram_address, ram_data, cur_exp[40:16], cur_exp[15:0]);
        end
      end
      we_d = ram_we;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_bit(input logic lr, input logic d);
    I2S_SCLK = 1'b0; I2S_LRCLK = lr; I2S_DOUT = d;
    #100;
    I2S_SCLK = 1'b1;
    #100;
  endtask

  // 32 SCLK per half frame: delay slot, 16 data bits MSB first, zero padding
  task automatic send_frame(input logic lr, input logic [15:0] w);
    for (int i = 0; i < 32; i++) send_bit(lr, (i >= 1 && i <= 16) ? w[16-i] : 1'b0);
  endtask

  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    send_frame(1'b0, l);
    send_frame(1'b1, r);
  endtask

  task automatic restart(input logic [24:0] s, input logic [24:0] e, input logic lp);
    @(posedge clk50); #1;
    enable = 1'b0;
    repeat (4) @(posedge clk50);
    #1;
    addr_start = s; addr_end = e; loop = lp;
    enable = 1'b1;
    repeat (2) @(posedge clk50);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((sb.size() != 0 || ram_we !== 1'b0) && n < 5000) begin
      @(posedge clk50); n++;
    end
    repeat (4) @(posedge clk50);
    checks++;
    if (sb.size() != 0 || ram_we !== 1'b0) begin
      errors++;
      $display("FAIL %s_drain: got %0d pending writes ram_we=%b, expected 0 pending", name, sb.size(), ram_we);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; enable = 1'b0; loop = 1'b0;
    addr_start = '0; addr_end = '0;
    I2S_SCLK = 1'b0; I2S_LRCLK = 1'b1; I2S_DOUT = 1'b0;
    repeat (3) @(posedge clk50);
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL reset_we: got %b, expected 0", ram_we); end
    checks++; if (ram_address !== 25'd0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", ram_address); end
    checks++; if (ram_data !== 16'd0) begin errors++; $display("FAIL reset_data: got %h, expected 0", ram_data); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
    checks++;
    if ({hex_out_5, hex_out_4, hex_out_3, hex_out_2, hex_out_1, hex_out_0} !== 24'd0) begin
      errors++; $display("FAIL reset_hex: got %h, expected 0", {hex_out_5, hex_out_4, hex_out_3, hex_out_2, hex_out_1, hex_out_0});
    end
    reset_n = 1'b1;
    repeat (2) @(posedge clk50);
  endtask

  task automatic test_basic();
    ack_en = 1'b1;
    restart(25'h100, 25'h1FF, 1'b1);
    send_frame(1'b1, 16'hFFFF);
    sb.push_back({25'h100, 16'hA5C3});
    sb.push_back({25'h101, 16'h1234});
    send_pair(16'hA5C3, 16'h1234);
    sb.push_back({25'h102, 16'h8001});
    sb.push_back({25'h103, 16'h7FFE});
    send_pair(16'h8001, 16'h7FFE);
    wait_drain("basic");
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done: got %b, expected 0", done); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL basic_overflow: got %b, expected 0", overflow); end
    checks++; if (ram_address !== 25'h104) begin errors++; $display("FAIL basic_next_addr: got %h, expected 104", ram_address); end
  endtask

  task automatic test_enable_mid_right();
    @(posedge clk50); #1;
    enable = 1'b0;
    addr_start = 25'h200; addr_end = 25'h2FF; loop = 1'b1;
    send_frame(1'b0, 16'h5555);
    fork
      send_frame(1'b1, 16'hDEAD);
      begin repeat (100) @(posedge clk50); #1; enable = 1'b1; end
    join
    sb.push_back({25'h200, 16'h0F0F});
    sb.push_back({25'h201, 16'h7777});
    send_pair(16'h0F0F, 16'h7777);
    wait_drain("mid_right");
  endtask

  task automatic test_overflow();
    int w0;
    ack_en = 1'b0;
    restart(25'h300, 25'h3FF, 1'b1);
    w0 = writes;
    sb.push_back({25'h300, 16'h1000});
    sb.push_back({25'h301, 16'h2000});
    sb.push_back({25'h302, 16'h1001});
    sb.push_back({25'h303, 16'h2001});
    sb.push_back({25'h304, 16'h1002});
    for (int i = 0; i < 20; i++) send_pair(16'h1000 + 16'(i), 16'h2000 + 16'(i));
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b, expected 1", overflow); end
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL ovf_pending_we: got %b, expected 1", ram_we); end
    checks++; if (ram_data !== 16'h1000) begin errors++; $display("FAIL ovf_pending_data: got %h, expected 1000", ram_data); end
    ack_en = 1'b1;
    wait_drain("overflow");
    checks++; if (writes - w0 != 5) begin errors++; $display("FAIL ovf_write_count: got %0d, expected 5", writes - w0); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b, expected 1", overflow); end
  endtask

  task automatic test_single_addr();
    int w0;
    ack_en = 1'b1;
    restart(25'h10, 25'h10, 1'b0);
    sb.push_back({25'h10, 16'hBEEF});
    send_pair(16'hBEEF, 16'hCAFE);
    wait_drain("single_stop");
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done: got %b, expected 1", done); end
    w0 = writes;
    send_pair(16'h1111, 16'h2222);
    repeat (10) @(posedge clk50);
    checks++; if (writes != w0) begin errors++; $display("FAIL halt_no_write: got %0d writes, expected 0", writes - w0); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL halt_done: got %b, expected 1", done); end
    restart(25'h10, 25'h10, 1'b1);
    sb.push_back({25'h10, 16'h0101});
    sb.push_back({25'h10, 16'h0202});
    sb.push_back({25'h10, 16'h0303});
    sb.push_back({25'h10, 16'h0404});
    send_pair(16'h0101, 16'h0202);
    send_pair(16'h0303, 16'h0404);
    wait_drain("single_loop");
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL loop_done: got %b, expected 0", done); end
    checks++; if (ram_address !== 25'h10) begin errors++; $display("FAIL loop_addr: got %h, expected 10", ram_address); end
    restart(25'h20, 25'h1F, 1'b0);
    sb.push_back({25'h20, 16'h4242});
    send_pair(16'h4242, 16'h4343);
    wait_drain("inverted");
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL inverted_done: got %b, expected 1", done); end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    ack_en = 1'b0;
    restart(25'h400, 25'h4FF, 1'b1);
    sb.push_back({25'h400, 16'h9ABC});
    send_pair(16'h9ABC, 16'h4321);
    checks++; if (ram_we !== 1'b1) begin errors++; $display("FAIL rst_pre_we: got %b, expected 1", ram_we); end
    @(negedge clk50); #2;
    reset_n = 1'b0;
    #1;
    checks++; if (ram_we !== 1'b0) begin errors++; $display("FAIL rst_async_we: got %b, expected 0", ram_we); end
    checks++; if (ram_address !== 25'd0) begin errors++; $display("FAIL rst_async_addr: got %h, expected 0", ram_address); end
    checks++; if (ram_data !== 16'd0) begin errors++; $display("FAIL rst_async_data: got %h, expected 0", ram_data); end
    checks++; if (overflow !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_async_status: got done=%b ovf=%b, expected 0 0", done, overflow); end
    repeat (3) @(posedge clk50);
    #1;
    reset_n = 1'b1;
    ack_en = 1'b1;
    w0 = writes;
    send_frame(1'b1, 16'h0000);
    send_pair(16'h1357, 16'h2468);
    repeat (10) @(posedge clk50);
    checks++; if (writes != w0) begin errors++; $display("FAIL rst_no_write: got %0d writes, expected 0", writes - w0); end
    restart(25'h500, 25'h5FF, 1'b1);
    sb.push_back({25'h500, 16'hAAAA});
    sb.push_back({25'h501, 16'h5555});
    send_pair(16'hAAAA, 16'h5555);
    wait_drain("rst_resume");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_enable_mid_right();
    test_overflow();
    test_single_addr();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2s_capture_writer.md
I2S_CAPTURE_WRITER -- requirements
Module: i2s_capture_writer

Interface
REQ-001 SHALL have parameter DATA_W, default 16, meaning bits captured per channel sample.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning sample buffer entries (power of 2).
REQ-003 SHALL have port clk50, input, 1, system clock (50 MHz).
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, capture run; synchronous level.
REQ-006 SHALL have port loop, input, 1, 1 = wrap at end of region, 0 = stop at end of region.
REQ-007 SHALL have ports addr_start and addr_end, input, 25 each, inclusive word-address region.
REQ-008 SHALL have ports I2S_SCLK, I2S_LRCLK and I2S_DOUT, input, 1 each, from the codec acting as I2S master (asynchronous to clk50).
REQ-009 SHALL have port ram_we, output, 1, write request to the SDRAM arbiter write port.
REQ-010 SHALL have port ram_address, output, 25, word address.
REQ-011 SHALL have port ram_data, output, 16, write data.
REQ-012 SHALL have port ram_op_begun, input, 1, one-cycle acknowledge from the arbiter.
REQ-013 SHALL have ports done and overflow, output, 1 each, sticky status.
REQ-014 SHALL have ports hex_out_5..hex_out_0, output, 4 each, showing ram_address[23:0] as nibbles, MSB on hex_out_5.

Function
REQ-015 SHALL pass I2S_SCLK, I2S_LRCLK and I2S_DOUT through 2-flop synchronizers, with all three at equal delay; requires SCLK period >= 8 clk50 cycles.
REQ-016 SHALL detect an SCLK rising edge as synced SCLK = 1 while its previous value = 0, and SHALL sample LRCLK and DOUT only on that cycle.
REQ-017 SHALL treat a rising edge where LRCLK differs from its value at the previous rising edge as the I2S delay slot; the next DATA_W rising edges SHALL shift in DOUT MSB-first.
REQ-018 SHALL ignore bits after the DATA_W-th until the next LRCLK change; the channel of a frame is the LRCLK value at its delay slot (0 = left).
REQ-019 SHALL, after enable rises, discard all frames until the first left frame (LRCLK 1->0), so stored data is interleaved L,R starting with L.
REQ-020 SHALL push a completed word into the FIFO on the clk50 cycle after its last bit; a partial word SHALL never be pushed.
REQ-021 SHALL drop the new word when the FIFO is full, set overflow = 1 (sticky until reset or enable rise), and leave FIFO contents unchanged.
REQ-022 SHALL, when a push and a pop occur in the same cycle, complete both with the FIFO count unchanged.
REQ-023 SHALL implement a writer FSM with states IDLE, WRITE, RELEASE and HALT.
REQ-024 SHALL move IDLE->WRITE when the FIFO is non-empty, not done and enable = 1; the pop SHALL load ram_data and assert ram_we on the same edge.
REQ-025 SHALL hold ram_we, ram_address and ram_data stable in WRITE until ram_op_begun = 1, then go WRITE->RELEASE with ram_we = 0.
REQ-026 SHALL update the address on exit from RELEASE: if ram_address != addr_end, add 1; else if loop = 1, load addr_start; else set done = 1 and enter HALT.
REQ-027 SHALL return RELEASE->IDLE, so there is at least 1 idle cycle between writes.
REQ-028 SHALL leave HALT only on an enable rising edge or on reset.
REQ-029 SHALL, when enable falls, abort capture at once (discard the partial word and flush the FIFO), while an in-flight WRITE runs to acknowledge and RELEASE.
REQ-030 SHALL, on an enable rising edge, load ram_address = addr_start and clear done and overflow.
REQ-031 SHALL ignore ram_op_begun outside WRITE.
REQ-032 SHALL keep addr_start/addr_end change effects to the next enable rising edge or to a wrap.
REQ-033 SHALL treat addr_end < addr_start as one write at addr_start followed by the end-of-region rule.

Reset
REQ-034 SHALL, with reset_n = 0, asynchronously set ram_we = 0, ram_address = 0, ram_data = 0, done = 0, overflow = 0, FIFO empty, shift/bit counters = 0, synchronizer flops = 0 and FSM = IDLE.
REQ-035 SHALL, when reset is asserted mid-write, drop ram_we immediately; after release it SHALL wait for an enable rising edge before writing.

Verification
REQ-036 SHALL pass: enable = 1, addr 0x100-0x1FF, codec sends L = 0xA5C3, R = 0x1234 (SCLK = 64x LRCLK) -> writes 0xA5C3 @0x100 then 0x1234 @0x101, each with ram_we held until ack.
REQ-037 SHALL pass: enable rises mid right frame -> that frame is discarded and the first write is the following left word.
REQ-038 SHALL pass: ram_op_begun held low for 40 samples, FIFO_DEPTH = 4 -> 1 write pending plus 4 queued, overflow = 1, and the later ack stream writes exactly those 5 words in order.
REQ-039 SHALL pass: addr_start = addr_end = 0x10 with loop = 0 -> 1 write, done = 1, HALT; with loop = 1 -> every write goes to 0x10, done = 0.
REQ-040 SHALL pass: reset_n pulsed low while ram_we = 1 -> ram_we = 0 in the same cycle, all outputs at reset values, no further write until enable rises again.
